// File: rtl/sig_ctrl_pkg.sv
// Shared types and constants for the PWM generator command controller.
// Command byte map, reply codes, configuration bundle and divider table.
package sig_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ARG,
        WAIT_WRAP,
        ACK
    } state_t;

    typedef enum logic [1:0] {
        K_SINGLE,
        K_PARAM,
        K_STATUS,
        K_BAD
    } cmd_kind_t;

    typedef struct packed {
        logic [31:0] freq_div;
        logic [1:0]  wave_sel;
        logic [1:0]  filter_level;
        logic        noise_en;
        logic        adsr_en;
        logic [7:0]  attack;
        logic [7:0]  decay;
        logic [7:0]  sustain;
        logic [7:0]  relax;
    } cfg_t;

    localparam logic [7:0] CMD_F0 = 8'h30;
    localparam logic [7:0] CMD_F7 = 8'h37;
    localparam logic [7:0] CMD_A  = 8'h41;
    localparam logic [7:0] CMD_D  = 8'h44;
    localparam logic [7:0] CMD_G  = 8'h47;
    localparam logic [7:0] CMD_H  = 8'h48;
    localparam logic [7:0] CMD_I  = 8'h49;
    localparam logic [7:0] CMD_J  = 8'h4A;
    localparam logic [7:0] CMD_K  = 8'h4B;
    localparam logic [7:0] CMD_L  = 8'h4C;
    localparam logic [7:0] CMD_M  = 8'h4D;
    localparam logic [7:0] CMD_P  = 8'h50;
    localparam logic [7:0] CMD_S  = 8'h53;
    localparam logic [7:0] CMD_T  = 8'h54;

    localparam logic [7:0] ACK_BYTE = 8'h21;
    localparam logic [7:0] NAK_BYTE = 8'h3F;

    localparam cfg_t CFG_RST = '{
        freq_div:     32'd100000,
        wave_sel:     2'd0,
        filter_level: 2'd0,
        noise_en:     1'b0,
        adsr_en:      1'b0,
        attack:       8'h10,
        decay:        8'h10,
        sustain:      8'h80,
        relax:        8'h10
    };

    function automatic logic [31:0] freq_lut(
        input int unsigned clk_hz,
        input logic [2:0]  n
    );
        logic [31:0] r;
        unique case (n)
            3'd0: r = 32'(clk_hz / 250);
            3'd1: r = 32'(clk_hz / 500);
            3'd2: r = 32'(clk_hz / 750);
            3'd3: r = 32'(clk_hz / 1000);
            3'd4: r = 32'(clk_hz / 1500);
            3'd5: r = 32'(clk_hz / 2000);
            3'd6: r = 32'(clk_hz / 3000);
            3'd7: r = 32'(clk_hz / 4000);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sig_cmd_ctrl_if.sv
// UART byte link between the receiver/transmitter pair and the controller.
// master is the UART side, slave is the command controller.
interface sig_cmd_ctrl_if;

    logic       rx_valid;
    logic [7:0] rx_data;
    logic       tx_busy;
    logic       tx_en;
    logic [7:0] tx_data;

    modport master (
        output rx_valid,
        output rx_data,
        output tx_busy,
        input  tx_en,
        input  tx_data
    );

    modport slave (
        input  rx_valid,
        input  rx_data,
        input  tx_busy,
        output tx_en,
        output tx_data
    );

endinterface

// File: rtl/sig_ctrl_timeout.sv
// Loadable down-counter guarding the gap between argument bytes.
// expire is raised on the LIMIT-th enabled cycle after a load.
module sig_ctrl_timeout #(
    parameter int unsigned LIMIT = 250000
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic load,
    input  logic clear,
    input  logic en,
    output logic expire
);

    localparam logic [31:0] RELOAD = 32'(LIMIT - 1);

    logic [31:0] cnt;

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= RELOAD;
        end else if (clear) begin
            cnt <= '0;
        end else if (en && cnt != '0) begin
            cnt <= cnt - 32'd1;
        end
    end

    assign expire = en && !load && (cnt == '0);

endmodule

// File: rtl/sig_cmd_ctrl.sv
// Command decoder for the PWM generator: stages settings in a shadow copy
// and commits them on a waveform wrap, then replies over the UART.
module sig_cmd_ctrl
    import sig_ctrl_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 25000000,
    parameter int unsigned ARG_TIMEOUT = CLK_HZ / 100
) (
    input  logic          clk1,
    input  logic          rst_n,
    sig_cmd_ctrl_if.slave link,
    input  logic          wave_wrap,
    output logic [31:0]   freq_div,
    output logic [1:0]    wave_sel,
    output logic [1:0]    filter_level,
    output logic          noise_en,
    output logic          adsr_en,
    output logic [7:0]    attack,
    output logic [7:0]    decay,
    output logic [7:0]    sustain,
    output logic [7:0]    relax,
    output logic          adsr_trig,
    output logic          busy,
    output logic          overrun
);

    state_t     state;
    state_t     state_next;
    cmd_kind_t  kind;
    cfg_t       active;
    cfg_t       shadow;
    cfg_t       dec_cfg;
    logic       dec_arm;
    logic       trig_arm;
    logic [1:0] arg_idx;
    logic [7:0] tx_byte;
    logic       tx_fire;
    logic       tmo_load;
    logic       tmo_clear;
    logic       tmo_expire;
    logic [7:0] rxd;

    assign rxd = link.rx_data;

    // Decoded settings are relative to the live configuration
    always_comb begin
        dec_cfg = active;
        dec_arm = 1'b0;
        kind    = K_SINGLE;
        unique case (1'b1)
            (rxd >= CMD_F0 && rxd <= CMD_F7):
                dec_cfg.freq_div = freq_lut(CLK_HZ, rxd[2:0]);
            (rxd >= CMD_A && rxd <= CMD_D):
                dec_cfg.wave_sel = rxd[1:0] - 2'd1;
            (rxd == CMD_G): dec_cfg.filter_level = 2'd0;
            (rxd == CMD_I): dec_cfg.filter_level = 2'd1;
            (rxd == CMD_J): dec_cfg.filter_level = 2'd2;
            (rxd == CMD_K): dec_cfg.filter_level = 2'd3;
            (rxd == CMD_H): dec_cfg.noise_en = ~active.noise_en;
            (rxd == CMD_L): dec_cfg.adsr_en = 1'b1;
            (rxd == CMD_M): dec_cfg.adsr_en = 1'b0;
            (rxd == CMD_T): dec_arm = 1'b1;
            (rxd == CMD_P): kind = K_PARAM;
            (rxd == CMD_S): kind = K_STATUS;
            default:        kind = K_BAD;
        endcase
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        tx_fire    = 1'b0;
        unique case (state)
            IDLE: begin
                if (link.rx_valid) begin
                    unique case (kind)
                        K_SINGLE: state_next = WAIT_WRAP;
                        K_PARAM:  state_next = ARG;
                        K_STATUS: state_next = ACK;
                        K_BAD:    state_next = ACK;
                    endcase
                end
            end
            ARG: begin
                if (link.rx_valid) begin
                    if (arg_idx == 2'd3) begin
                        state_next = WAIT_WRAP;
                    end
                end else if (tmo_expire) begin
                    state_next = ACK;
                end
            end
            WAIT_WRAP: begin
                if (wave_wrap) begin
                    state_next = ACK;
                end
            end
            ACK: begin
                if (!link.tx_busy) begin
                    tx_fire    = 1'b1;
                    state_next = IDLE;
                end
            end
        endcase
    end

    assign tmo_load  = link.rx_valid &&
                       ((state == IDLE && kind == K_PARAM) ||
                        state == ARG);
    assign tmo_clear = (state != ARG);

    sig_ctrl_timeout #(
        .LIMIT (ARG_TIMEOUT)
    ) u_timeout (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .load   (tmo_load),
        .clear  (tmo_clear),
        .en     (state == ARG),
        .expire (tmo_expire)
    );

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            active    <= CFG_RST;
            shadow    <= CFG_RST;
            trig_arm  <= 1'b0;
            adsr_trig <= 1'b0;
            arg_idx   <= 2'd0;
            tx_byte   <= 8'h00;
            overrun   <= 1'b0;
        end else begin
            adsr_trig <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (link.rx_valid) begin
                        unique case (kind)
                            K_SINGLE: begin
                                shadow   <= dec_cfg;
                                trig_arm <= dec_arm;
                            end
                            K_PARAM: arg_idx <= 2'd0;
                            K_STATUS: begin
                                tx_byte <= {6'b0, overrun, active.adsr_en};
                                overrun <= 1'b0;
                            end
                            K_BAD: tx_byte <= NAK_BYTE;
                        endcase
                    end
                end
                ARG: begin
                    if (link.rx_valid) begin
                        unique case (arg_idx)
                            2'd0: shadow.attack  <= rxd;
                            2'd1: shadow.decay   <= rxd;
                            2'd2: shadow.sustain <= rxd;
                            2'd3: shadow.relax   <= rxd;
                        endcase
                        arg_idx <= arg_idx + 2'd1;
                    end else if (tmo_expire) begin
                        shadow  <= active;
                        tx_byte <= NAK_BYTE;
                    end
                end
                WAIT_WRAP: begin
                    if (link.rx_valid) begin
                        overrun <= 1'b1;
                    end
                    if (wave_wrap) begin
                        active    <= shadow;
                        adsr_trig <= trig_arm;
                        trig_arm  <= 1'b0;
                        tx_byte   <= ACK_BYTE;
                    end
                end
                ACK: begin
                    if (link.rx_valid) begin
                        overrun <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy         = (state != IDLE);
    assign link.tx_en   = tx_fire;
    assign link.tx_data = tx_byte;
    assign freq_div     = active.freq_div;
    assign wave_sel     = active.wave_sel;
    assign filter_level = active.filter_level;
    assign noise_en     = active.noise_en;
    assign adsr_en      = active.adsr_en;
    assign attack       = active.attack;
    assign decay        = active.decay;
    assign sustain      = active.sustain;
    assign relax        = active.relax;

endmodule

// File: tb/tb_sig_cmd_ctrl.sv
// Directed bench for the PWM command controller.
// Short ARG_TIMEOUT keeps the timeout case quick.
module tb_sig_cmd_ctrl;

    logic        clk1 = 1'b0;
    logic        rst_n;
    logic        wave_wrap;
    logic [31:0] freq_div;
    logic [1:0]  wave_sel;
    logic [1:0]  filter_level;
    logic        noise_en;
    logic        adsr_en;
    logic [7:0]  attack;
    logic [7:0]  decay;
    logic [7:0]  sustain;
    logic [7:0]  relax;
    logic        adsr_trig;
    logic        busy;
    logic        overrun;

    int          tests = 0;
    int          fails = 0;
    int          tx_cnt = 0;
    logic [7:0]  tx_last = 8'h00;

    sig_cmd_ctrl_if link();

    always #5 clk1 = ~clk1;

    sig_cmd_ctrl #(
        .CLK_HZ      (25000000),
        .ARG_TIMEOUT (200)
    ) dut (
        .clk1         (clk1),
        .rst_n        (rst_n),
        .link         (link),
        .wave_wrap    (wave_wrap),
        .freq_div     (freq_div),
        .wave_sel     (wave_sel),
        .filter_level (filter_level),
        .noise_en     (noise_en),
        .adsr_en      (adsr_en),
        .attack       (attack),
        .decay        (decay),
        .sustain      (sustain),
        .relax        (relax),
        .adsr_trig    (adsr_trig),
        .busy         (busy),
        .overrun      (overrun)
    );

    always @(negedge clk1) begin
        if (link.tx_en === 1'b1) begin
            tx_cnt  = tx_cnt + 1;
            tx_last = link.tx_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk1);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        link.rx_valid = 1'b1;
        link.rx_data  = b;
        tick();
        link.rx_valid = 1'b0;
    endtask

    task automatic wrap();
        wave_wrap = 1'b1;
        tick();
        wave_wrap = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n         = 1'b0;
        wave_wrap     = 1'b0;
        link.rx_valid = 1'b0;
        link.rx_data  = 8'h00;
        link.tx_busy  = 1'b0;
        repeat (3) tick();
        chk("rst_freq", freq_div, 32'd100000);
        chk("rst_wave", {30'd0, wave_sel}, 32'd0);
        chk("rst_filt", {30'd0, filter_level}, 32'd0);
        chk("rst_noise_adsr", {30'd0, noise_en, adsr_en}, 32'd0);
        chk("rst_adsr_par", {attack, decay, sustain, relax}, 32'h10108010);
        chk("rst_flags", {27'd0, link.tx_en, adsr_trig, busy, overrun, 1'b0}, 32'd0);
        chk("rst_txdata", {24'd0, link.tx_data}, 32'd0);
        rst_n = 1'b1;
        tick();

        // 'B' with a coincident wrap: no commit until the next wrap
        wave_wrap     = 1'b1;
        send(8'h42);
        wave_wrap     = 1'b0;
        chk("b_busy", {31'd0, busy}, 32'd1);
        repeat (5) tick();
        chk("b_hold", {30'd0, wave_sel}, 32'd0);
        wrap();
        chk("b_commit", {30'd0, wave_sel}, 32'd1);
        chk("b_txen", {31'd0, link.tx_en}, 32'd1);
        chk("b_txdata", {24'd0, link.tx_data}, 32'h21);
        tick();
        chk("b_txcnt", tx_cnt, 32'd1);
        chk("b_idle", {30'd0, busy, link.tx_en}, 32'd0);

        // '7' with the transmitter busy
        link.tx_busy = 1'b1;
        send(8'h37);
        wrap();
        chk("f7_freq", freq_div, 32'd6250);
        repeat (498) tick();
        chk("f7_held_cnt", tx_cnt, 32'd1);
        chk("f7_held_busy", {30'd0, busy, link.tx_en}, 32'd2);
        link.tx_busy = 1'b0;
        #1;
        chk("f7_txen", {31'd0, link.tx_en}, 32'd1);
        tick();
        chk("f7_txcnt", tx_cnt, 32'd2);
        chk("f7_last", {24'd0, tx_last}, 32'h21);

        // 'T' trigger pulse
        send(8'h54);
        chk("t_pre", {31'd0, adsr_trig}, 32'd0);
        wrap();
        chk("t_pulse", {31'd0, adsr_trig}, 32'd1);
        tick();
        chk("t_low", {31'd0, adsr_trig}, 32'd0);

        // 'P' with four arguments
        send(8'h50);
        send(8'h20);
        send(8'h30);
        send(8'h40);
        send(8'h50);
        chk("p_wait", {31'd0, busy}, 32'd1);
        chk("p_hold", {24'd0, attack}, 32'h10);
        wrap();
        chk("p_adsr", {attack, decay, sustain, relax}, 32'h20304050);
        tick();
        chk("p_txcnt", tx_cnt, 32'd4);
        chk("p_last", {24'd0, tx_last}, 32'h21);

        // 'P' then silence past the timeout
        send(8'h50);
        send(8'h77);
        repeat (150) tick();
        chk("to_still_arg", {31'd0, busy}, 32'd1);
        repeat (70) tick();
        chk("to_idle", {31'd0, busy}, 32'd0);
        chk("to_txcnt", tx_cnt, 32'd5);
        chk("to_nak", {24'd0, tx_last}, 32'h3F);
        chk("to_adsr", {attack, decay, sustain, relax}, 32'h20304050);
        send(8'h4C);
        wrap();
        chk("to_discard", {24'd0, attack}, 32'h20);
        chk("l_adsr_en", {31'd0, adsr_en}, 32'd1);
        tick();

        // 'A' then 'C' dropped, status query, unknown byte
        send(8'h41);
        send(8'h43);
        chk("ov_set", {31'd0, overrun}, 32'd1);
        wrap();
        chk("ov_wave", {30'd0, wave_sel}, 32'd0);
        tick();
        chk("ov_txcnt", tx_cnt, 32'd7);
        send(8'h53);
        chk("s_reply", {24'd0, link.tx_data}, 32'h03);
        chk("s_clear", {31'd0, overrun}, 32'd0);
        tick();
        send(8'h5A);
        tick();
        chk("z_txcnt", tx_cnt, 32'd9);
        chk("z_nak", {24'd0, tx_last}, 32'h3F);
        chk("z_wave", {30'd0, wave_sel}, 32'd0);

        // noise toggle and filter level
        send(8'h48);
        wrap();
        chk("h_noise", {31'd0, noise_en}, 32'd1);
        tick();
        send(8'h4B);
        wrap();
        chk("k_filter", {30'd0, filter_level}, 32'd3);
        tick();
        chk("hk_txcnt", tx_cnt, 32'd11);

        // reset while waiting for a wrap
        send(8'h44);
        chk("r_busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("r_freq", freq_div, 32'd100000);
        chk("r_cfg", {26'd0, wave_sel, filter_level, noise_en, adsr_en}, 32'd0);
        chk("r_flags", {29'd0, busy, link.tx_en, overrun}, 32'd0);
        #3;
        rst_n = 1'b1;
        repeat (2) tick();
        wrap();
        chk("r_nocommit", {30'd0, wave_sel}, 32'd0);
        repeat (3) tick();
        chk("r_notx", tx_cnt, 32'd11);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
